bilinear_interp_core: RTL and testbench
=======================================

BILINEAR_INTERP_CORE -- requirements
Module: bilinear_interp_core

Interface
- REQ-001 SHALL have parameter CH_NUM, default 3: number of colour channels per pixel.
- REQ-002 SHALL have parameter CH_W, default 8: bits per channel. Pixel width is CH_NUM*CH_W, with channel CH_NUM-1 in the MSBs (RGB888 by default).
- REQ-003 SHALL have parameter FRAC_W, default 4: fractional weight width.
- REQ-004 Port clk, input, 1 bit: the single clock.
- REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-006 Port frame_rst, input, 1: clears the decimation phase.
- REQ-007 Port dec_en, input, 1: 1 selects 2:1 horizontal and vertical decimation; 0 passes every valid sample.
- REQ-008 Ports frame_i_vs, frame_i_hs and frame_i_valid, input, 1 each: input sideband.
- REQ-009 Ports frame_i_data_00, _01, _10 and _11, input, CH_NUM*CH_W each: the four neighbours (row, column).
- REQ-010 Ports frame_i_wx and frame_i_wy, input, FRAC_W each: horizontal and vertical weights toward column 1 and row 1.
- REQ-011 Ports frame_o_vs, frame_o_hs and frame_o_valid, output, 1 each: delayed sideband.
- REQ-012 Port frame_o_data, output, CH_NUM*CH_W: interpolated pixel.

Function
- REQ-013 Per channel, with S = 2^FRAC_W, stage 1 SHALL register a = p00*(S-wx) + p01*wx and b = p10*(S-wx) + p11*wx. Each is CH_W+FRAC_W bits, unsigned.
- REQ-014 Stage 2 SHALL register c = a*(S-wy) + b*wy, CH_W+2*FRAC_W bits.
- REQ-015 Stage 3 SHALL register the output channel as c >> 2*FRAC_W, with rounding per REQ-026/027. The result SHALL be clamped to 2^CH_W-1.
- REQ-016 Latency SHALL be exactly 3 clk for data and all sideband.
  - frame_o_vs and frame_o_hs equal frame_i_vs and frame_i_hs delayed 3 cycles.
  - frame_o_valid equals keep (REQ-019) delayed 3 cycles.
- REQ-017 The pipeline SHALL run every cycle (no stall). Data on cycles with keep=0 is don't-care.
- REQ-018 An hs rising edge SHALL be detected when frame_i_hs=1 and the registered previous frame_i_hs=0, with no extra delay.
- REQ-019 keep SHALL be computed as follows:
  - If dec_en=0: keep = frame_i_valid.
  - If dec_en=1: keep = frame_i_valid & h_phase & v_phase.
- REQ-020 h_phase, which resets to 0:
  - SHALL clear on an hs rising edge;
  - otherwise SHALL toggle on each cycle with frame_i_valid=1.
  - As a result, the 2nd, 4th, … valid pixel of each line is kept.
- REQ-021 v_phase, which resets to 1, SHALL toggle on each hs rising edge. As a result, the 1st, 3rd, … lines are kept.
- REQ-022 If frame_rst is asserted, h_phase:=0 and v_phase:=1, overriding simultaneous valid or hs edge events. keep is still computed from the pre-update phases that cycle.
- REQ-023 If an hs rising edge coincides with frame_i_valid:
  - h_phase SHALL clear, taking priority over the toggle;
  - keep SHALL use the pre-edge h_phase.
- REQ-024 Boundary weights SHALL give exact results (no rounding error):
  - wx=0, wy=0 SHALL output p00 exactly;
  - wx=0 with any wy SHALL give pure vertical interpolation of column 0.
  - Weight S itself is unreachable by design.

Reset
- REQ-025 While rst=1 at a clk edge, the following SHALL be 0 on the next cycle:
  - all pipeline data registers, frame_o_data, frame_o_vs, frame_o_hs and frame_o_valid;
  - h_phase and the previous-hs register.
  - v_phase SHALL instead become 1.
  - Reset mid-line SHALL discard all in-flight samples, with no valid output until 3 cycles after the first post-reset keep.

Configuration
- REQ-026 With macro BILINEAR_ROUND_EN defined, stage 3 SHALL add 2^(2*FRAC_W-1) before the shift (round half up).
- REQ-027 Without BILINEAR_ROUND_EN, stage 3 SHALL truncate. Latency is identical in both builds.

Verification
- REQ-028 CH_W=8, FRAC_W=4, dec_en=0; p00=100, p01=200, p10=0, p11=40; wx=8, wy=8, valid=1 -> output 85 on every channel, 3 cycles later, with frame_o_valid=1.
- REQ-029 p00=3, others 0, wx=8, wy=8 -> output 1 with BILINEAR_ROUND_EN, 0 without.
- REQ-030 wx=0, wy=0, p00=0xABCDEF, other pixels random -> frame_o_data=0xABCDEF.
- REQ-031 dec_en=1; 3 lines of 8 valid pixels, each line preceded by an hs rising edge:
  - after the initial v toggle, valid outputs appear only on line 2, pixels 2, 4, 6 and 8;
  - the valid count is 4 per kept line;
  - alternate lines give 0.
- REQ-032 frame_rst pulse asserted together with an hs rising edge mid-frame -> v_phase=1 and h_phase=0 afterwards (the hs edge has no toggle effect). The next line's output pattern matches the first line of a fresh frame.
- REQ-033 rst asserted for 1 cycle while valid samples are in flight -> frame_o_valid=0 for the following 3 cycles, then resumes with correct data.

Source files
------------

// File: rtl/bilinear_interp_core.sv
// bilinear_interp_core: three-stage bilinear pixel interpolator with an optional
// 2:1 horizontal/vertical decimator driving the output valid.
// Stage 1 blends horizontally, stage 2 blends vertically, stage 3 scales and clamps.
// Build option: define BILINEAR_ROUND_EN for round-half-up in stage 3; otherwise truncate.
`timescale 1ns/1ps

module bilinear_interp_core #(
    parameter int CH_NUM = 3,
    parameter int CH_W   = 8,
    parameter int FRAC_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_rst,
    input  logic                     dec_en,
    input  logic                     frame_i_vs,
    input  logic                     frame_i_hs,
    input  logic                     frame_i_valid,
    input  logic [CH_NUM*CH_W-1:0]   frame_i_data_00,
    input  logic [CH_NUM*CH_W-1:0]   frame_i_data_01,
    input  logic [CH_NUM*CH_W-1:0]   frame_i_data_10,
    input  logic [CH_NUM*CH_W-1:0]   frame_i_data_11,
    input  logic [FRAC_W-1:0]        frame_i_wx,
    input  logic [FRAC_W-1:0]        frame_i_wy,
    output logic                     frame_o_vs,
    output logic                     frame_o_hs,
    output logic                     frame_o_valid,
    output logic [CH_NUM*CH_W-1:0]   frame_o_data
);

    localparam int PW = CH_NUM * CH_W;
    localparam int AW = CH_W + FRAC_W;
    localparam int CW = CH_W + 2 * FRAC_W;

    // Weight of 1.0; a FRAC_W-bit weight can never reach it.
    localparam logic [FRAC_W:0] S_VAL   = {1'b1, {FRAC_W{1'b0}}};
    localparam logic [CH_W:0]   MAX_VAL = {1'b0, {CH_W{1'b1}}};
`ifdef BILINEAR_ROUND_EN
    localparam logic [CW:0]     RND_VAL = (CW + 1)'(1) << (2 * FRAC_W - 1);
`else
    localparam logic [CW:0]     RND_VAL = '0;
`endif

    // Decimation state
    logic hs_prev_q,  hs_prev_d;
    logic h_phase_q,  h_phase_d;
    logic v_phase_q,  v_phase_d;

    // Datapath pipeline
    logic [CH_NUM-1:0][AW-1:0] a_q, a_d;
    logic [CH_NUM-1:0][AW-1:0] b_q, b_d;
    logic [FRAC_W-1:0]         wy_q, wy_d;
    logic [CH_NUM-1:0][CW-1:0] c_q, c_d;
    logic [PW-1:0]             out_q, out_d;

    // Sideband delay lines, bit 2 is the output tap
    logic [2:0] vs_q,    vs_d;
    logic [2:0] hs_q,    hs_d;
    logic [2:0] valid_q, valid_d;

    logic              hs_rise;
    logic              keep;
    logic [FRAC_W:0]   wx_inv;
    logic [FRAC_W:0]   wy_inv;

    // Next-state for decimator phases, datapath stages and sideband delay lines
    always_comb begin
        logic [CW:0]   sum;
        logic [CH_W:0] shr;

        sum     = '0;
        shr     = '0;
        a_d     = '0;
        b_d     = '0;
        c_d     = '0;
        out_d   = '0;

        hs_rise = frame_i_hs & ~hs_prev_q;
        // Keep decision uses the phases as they stand before this cycle's update.
        keep    = dec_en ? (frame_i_valid & h_phase_q & v_phase_q) : frame_i_valid;

        hs_prev_d = frame_i_hs;
        h_phase_d = h_phase_q;
        v_phase_d = v_phase_q;
        if (frame_rst) begin
            h_phase_d = 1'b0;
            v_phase_d = 1'b1;
        end else begin
            if (hs_rise) begin
                h_phase_d = 1'b0;
                v_phase_d = ~v_phase_q;
            end else if (frame_i_valid) begin
                h_phase_d = ~h_phase_q;
            end
        end

        wx_inv = S_VAL - {1'b0, frame_i_wx};
        wy_inv = S_VAL - {1'b0, wy_q};

        for (int ch = 0; ch < CH_NUM; ch++) begin
            a_d[ch] = AW'(frame_i_data_00[ch*CH_W +: CH_W]) * AW'(wx_inv)
                    + AW'(frame_i_data_01[ch*CH_W +: CH_W]) * AW'(frame_i_wx);
            b_d[ch] = AW'(frame_i_data_10[ch*CH_W +: CH_W]) * AW'(wx_inv)
                    + AW'(frame_i_data_11[ch*CH_W +: CH_W]) * AW'(frame_i_wx);

            c_d[ch] = CW'(a_q[ch]) * CW'(wy_inv) + CW'(b_q[ch]) * CW'(wy_q);

            sum = {1'b0, c_q[ch]} + RND_VAL;
            shr = sum[CW:2*FRAC_W];
            out_d[ch*CH_W +: CH_W] = (shr > MAX_VAL) ? MAX_VAL[CH_W-1:0] : shr[CH_W-1:0];
        end

        wy_d    = frame_i_wy;
        vs_d    = {vs_q[1:0],    frame_i_vs};
        hs_d    = {hs_q[1:0],    frame_i_hs};
        valid_d = {valid_q[1:0], keep};
    end

    // Register all state; reset clears the pipeline and reopens the vertical phase
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_prev_q <= 1'b0;
            h_phase_q <= 1'b0;
            v_phase_q <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            wy_q      <= '0;
            c_q       <= '0;
            out_q     <= '0;
            vs_q      <= '0;
            hs_q      <= '0;
            valid_q   <= '0;
        end else begin
            hs_prev_q <= hs_prev_d;
            h_phase_q <= h_phase_d;
            v_phase_q <= v_phase_d;
            a_q       <= a_d;
            b_q       <= b_d;
            wy_q      <= wy_d;
            c_q       <= c_d;
            out_q     <= out_d;
            vs_q      <= vs_d;
            hs_q      <= hs_d;
            valid_q   <= valid_d;
        end
    end

    assign frame_o_vs    = vs_q[2];
    assign frame_o_hs    = hs_q[2];
    assign frame_o_valid = valid_q[2];
    assign frame_o_data  = out_q;

endmodule

// File: tb/tb_bilinear_interp_core.sv
// Testbench for bilinear_interp_core: directed scenarios plus a randomized run,
// all checked against a line/pixel-counting reference model with plain arithmetic.
`timescale 1ns/1ps

module tb_bilinear_interp_core;

    localparam int CH_NUM = 3;
    localparam int CH_W   = 8;
    localparam int FRAC_W = 4;
    localparam int PW     = CH_NUM * CH_W;

    logic          clk;
    logic          rst, frame_rst, dec_en;
    logic          i_vs, i_hs, i_valid;
    logic [PW-1:0] d00, d01, d10, d11;
    logic [3:0]    wx, wy;
    logic          o_vs, o_hs, o_valid;
    logic [PW-1:0] o_data;

    bilinear_interp_core #(.CH_NUM(CH_NUM), .CH_W(CH_W), .FRAC_W(FRAC_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .frame_rst       (frame_rst),
        .dec_en          (dec_en),
        .frame_i_vs      (i_vs),
        .frame_i_hs      (i_hs),
        .frame_i_valid   (i_valid),
        .frame_i_data_00 (d00),
        .frame_i_data_01 (d01),
        .frame_i_data_10 (d10),
        .frame_i_data_11 (d11),
        .frame_i_wx      (wx),
        .frame_i_wy      (wy),
        .frame_o_vs      (o_vs),
        .frame_o_hs      (o_hs),
        .frame_o_valid   (o_valid),
        .frame_o_data    (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          vs;
        logic          hs;
        logic          valid;
        logic          chk;
        logic [PW-1:0] data;
        int            tag;
    } ent_t;

    ent_t pipe [3];
    int   line_cnt, pix_cnt;
    logic prev_hs;
    int   n_vec, n_err;
    int   kept_q[$];
    int   cur_tag;

    function automatic logic [PW-1:0] ref_pix(input logic [PW-1:0] p00, input logic [PW-1:0] p01,
                                              input logic [PW-1:0] p10, input logic [PW-1:0] p11,
                                              input logic [3:0] x4, input logic [3:0] y4);
        logic [PW-1:0] r;
        int unsigned   x, y, c;
        r = '0;
        x = x4;
        y = y4;
        for (int ch = 0; ch < CH_NUM; ch++) begin
            c = (p00[ch*8 +: 8] * (16 - x) + p01[ch*8 +: 8] * x) * (16 - y)
              + (p10[ch*8 +: 8] * (16 - x) + p11[ch*8 +: 8] * x) * y;
`ifdef BILINEAR_ROUND_EN
            c = c + 128;
`endif
            c = c / 256;
            if (c > 255) c = 255;
            r[ch*8 +: 8] = 8'(c);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: model the cycle from the current inputs, advance, compare outputs.
    task automatic cycle();
        ent_t e;
        logic hs_rise, keep;
        hs_rise = i_hs && !prev_hs;
        if (dec_en) keep = i_valid && (pix_cnt % 2 == 1) && (line_cnt % 2 == 0);
        else        keep = i_valid;
        e.vs    = i_vs;
        e.hs    = i_hs;
        e.valid = keep;
        e.chk   = keep;
        e.data  = ref_pix(d00, d01, d10, d11, wx, wy);
        e.tag   = cur_tag;
        if (frame_rst) begin
            line_cnt = 0;
            pix_cnt  = 0;
        end else if (hs_rise) begin
            line_cnt++;
            pix_cnt = 0;
        end else if (i_valid) begin
            pix_cnt++;
        end
        prev_hs = i_hs;

        @(posedge clk);
        #1;
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                pipe[k].vs = 1'b0; pipe[k].hs = 1'b0; pipe[k].valid = 1'b0;
                pipe[k].chk = 1'b1; pipe[k].data = '0; pipe[k].tag = -1;
            end
            line_cnt = 0;
            pix_cnt  = 0;
            prev_hs  = 1'b0;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = e;
        end
        chk("vs",    PW'(o_vs),    PW'(pipe[2].vs));
        chk("hs",    PW'(o_hs),    PW'(pipe[2].hs));
        chk("valid", PW'(o_valid), PW'(pipe[2].valid));
        if (pipe[2].chk) chk("data", o_data, pipe[2].data);
        if (o_valid === 1'b1) kept_q.push_back(pipe[2].tag);
    endtask

    task automatic rand_pix();
        d00 = PW'($urandom); d01 = PW'($urandom);
        d10 = PW'($urandom); d11 = PW'($urandom);
        wx  = 4'($urandom);  wy  = 4'($urandom);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0; i_hs = 1'b0; frame_rst = 1'b0;
        cur_tag = 0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    // hs pulse on its own cycle, then npix valid pixels tagged line*100+pixel.
    task automatic do_line(input int ln, input int npix);
        i_hs = 1'b1; i_valid = 1'b0; cur_tag = 0;
        cycle();
        i_hs = 1'b0;
        for (int p = 1; p <= npix; p++) begin
            rand_pix();
            i_valid = 1'b1;
            cur_tag = ln * 100 + p;
            cycle();
        end
        i_valid = 1'b0;
        cur_tag = 0;
        cycle();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        line_cnt = 0; pix_cnt = 0; prev_hs = 1'b0; cur_tag = 0;
        for (int k = 0; k < 3; k++) begin
            pipe[k].vs = 1'b0; pipe[k].hs = 1'b0; pipe[k].valid = 1'b0;
            pipe[k].chk = 1'b1; pipe[k].data = '0; pipe[k].tag = -1;
        end
        rst = 1'b1; frame_rst = 1'b0; dec_en = 1'b0;
        i_vs = 1'b0; i_hs = 1'b0; i_valid = 1'b0;
        d00 = '0; d01 = '0; d10 = '0; d11 = '0; wx = '0; wy = '0;

        // Reset state
        cycle();
        cycle();
        chk("rst_data",  o_data,         '0);
        chk("rst_valid", PW'(o_valid),   '0);
        rst = 1'b0;

        // Mid-point blend of a known quad
        d00 = {3{8'd100}}; d01 = {3{8'd200}}; d10 = {3{8'd0}}; d11 = {3{8'd40}};
        wx = 4'd8; wy = 4'd8; i_valid = 1'b1;
        cycle();
        i_valid = 1'b0;
        cycle();
        cycle();
        chk("mid_data",  o_data,       {3{8'd85}});
        chk("mid_valid", PW'(o_valid), PW'(1'b1));

        // Rounding versus truncation on a small value
        d00 = {3{8'd3}}; d01 = '0; d10 = '0; d11 = '0; wx = 4'd8; wy = 4'd8; i_valid = 1'b1;
        cycle();
        i_valid = 1'b0;
        cycle();
        cycle();
`ifdef BILINEAR_ROUND_EN
        chk("round_data", o_data, {3{8'd1}});
`else
        chk("round_data", o_data, {3{8'd0}});
`endif

        // Zero weights pass p00 exactly
        rand_pix();
        d00 = 24'hABCDEF; wx = 4'd0; wy = 4'd0; i_valid = 1'b1;
        cycle();
        i_valid = 1'b0;
        cycle();
        cycle();
        chk("zero_w_data", o_data, 24'hABCDEF);

        // Column-0 vertical interpolation only
        for (int k = 0; k < 6; k++) begin
            rand_pix();
            wx = 4'd0; i_valid = 1'b1;
            cycle();
        end
        idle(3);

        // Decimation over three lines
        dec_en = 1'b1;
        idle(4);
        frame_rst = 1'b1;
        cycle();
        frame_rst = 1'b0;
        kept_q.delete();
        do_line(1, 8);
        do_line(2, 8);
        do_line(3, 8);
        idle(4);
        chk("dec_count", PW'(kept_q.size()), PW'(4));
        if (kept_q.size() == 4) begin
            chk("dec_pos0", PW'(kept_q[0]), PW'(202));
            chk("dec_pos1", PW'(kept_q[1]), PW'(204));
            chk("dec_pos2", PW'(kept_q[2]), PW'(206));
            chk("dec_pos3", PW'(kept_q[3]), PW'(208));
        end

        // frame_rst coinciding with an hs edge mid-frame: phases restart, no toggle
        do_line(4, 4);
        idle(4);
        kept_q.delete();
        frame_rst = 1'b1; i_hs = 1'b1; i_valid = 1'b0;
        cycle();
        frame_rst = 1'b0; i_hs = 1'b0;
        for (int p = 1; p <= 8; p++) begin
            rand_pix();
            i_valid = 1'b1;
            cur_tag = 900 + p;
            cycle();
        end
        idle(4);
        chk("frst_count", PW'(kept_q.size()), PW'(4));
        if (kept_q.size() > 0) chk("frst_first", PW'(kept_q[0]), PW'(902));

        // Reset while samples are in flight
        dec_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rand_pix(); i_valid = 1'b1; cycle();
        end
        rand_pix(); rst = 1'b1;
        cycle();
        chk("rst_flush0", PW'(o_valid), '0);
        rst = 1'b0;
        rand_pix();
        cycle();
        chk("rst_flush1", PW'(o_valid), '0);
        rand_pix();
        cycle();
        chk("rst_flush2", PW'(o_valid), '0);
        rand_pix();
        cycle();
        chk("rst_resume", PW'(o_valid), PW'(1'b1));
        idle(3);

        // Randomized traffic with occasional hs, vs, frame_rst and rst
        for (int n = 0; n < 2000; n++) begin
            if (n % 150 == 0) dec_en = 1'($urandom);
            rand_pix();
            i_valid   = ($urandom_range(0, 3) != 0);
            i_hs      = ($urandom_range(0, 11) == 0);
            i_vs      = ($urandom_range(0, 19) == 0);
            frame_rst = ($urandom_range(0, 59) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            cur_tag   = 0;
            cycle();
        end
        rst = 1'b0; frame_rst = 1'b0; i_vs = 1'b0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
